// File: rtl/cv32e40s_lockstep_pkg.sv
// Shared types and default sizing for the lockstep fault handler.
package cv32e40s_lockstep_pkg;

    localparam int unsigned CONFIRM_CYCLES_DEFAULT = 2;
    localparam int unsigned CNT_W_DEFAULT          = 8;
    localparam int unsigned RUN_CNT_W              = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HALT    = 2'd2,
        ST_RECOVER = 2'd3
    } lockstep_state_e;

endpackage

// File: rtl/cv32e40s_sat_counter.sv
// Event counter that sticks at all-ones; clear has priority over increment.
module cv32e40s_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/cv32e40s_lockstep_fault_handler.sv
// Filters comparator mismatches into confirmed faults and sequences halt/resync
// of the master and checker cores.
module cv32e40s_lockstep_fault_handler
    import cv32e40s_lockstep_pkg::*;
#(
    parameter int unsigned CONFIRM_CYCLES = CONFIRM_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             error_i,
    input  logic             halt_ack_i,
    input  logic             recover_done_i,
    input  logic             clear_i,
    output logic             alert_o,
    output logic             halt_req_o,
    output logic             recover_req_o,
    output logic             fault_sticky_o,
    output logic [CNT_W-1:0] transient_cnt_o,
    output logic [CNT_W-1:0] fault_cnt_o
);

    localparam logic [RUN_CNT_W-1:0] CONFIRM_LIM = RUN_CNT_W'(CONFIRM_CYCLES);

    lockstep_state_e      state_q, state_d;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 alert_q, alert_d;
    logic                 halt_req_q, halt_req_d;
    logic                 recover_req_q, recover_req_d;
    logic                 sticky_q, sticky_d;
    logic                 transient_inc;
    logic                 fault_inc;

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        transient_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i && error_i) begin
                    if (CONFIRM_LIM == RUN_CNT_W'(1)) begin
                        state_d   = ST_HALT;
                        run_cnt_d = '0;
                    end else begin
                        state_d   = ST_CONFIRM;
                        run_cnt_d = RUN_CNT_W'(1);
                    end
                end
            end
            ST_CONFIRM: begin
                if (!enable_i) begin
                    state_d   = ST_IDLE;
                    run_cnt_d = '0;
                end else if (error_i) begin
                    if ((run_cnt_q + RUN_CNT_W'(1)) == CONFIRM_LIM) begin
                        state_d   = ST_HALT;
                        run_cnt_d = '0;
                    end else begin
                        run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
                    end
                end else begin
                    state_d       = ST_IDLE;
                    run_cnt_d     = '0;
                    transient_inc = 1'b1;
                end
            end
            // Ack only counts once the request is visible to the cores.
            ST_HALT: begin
                if (halt_req_q && halt_ack_i) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (recover_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                run_cnt_d = '0;
            end
        endcase

        fault_inc     = (state_d == ST_HALT) && (state_q != ST_HALT);
        alert_d       = fault_inc;
        halt_req_d    = (state_q == ST_HALT) && (state_d == ST_HALT);
        recover_req_d = (state_d == ST_RECOVER);
        sticky_d      = clear_i ? 1'b0 : (sticky_q | fault_inc);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            run_cnt_q     <= '0;
            alert_q       <= 1'b0;
            halt_req_q    <= 1'b0;
            recover_req_q <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            alert_q       <= alert_d;
            halt_req_q    <= halt_req_d;
            recover_req_q <= recover_req_d;
            sticky_q      <= sticky_d;
        end
    end

    cv32e40s_sat_counter #(.WIDTH(CNT_W)) u_transient_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (transient_inc),
        .clr_i   (clear_i),
        .count_o (transient_cnt_o)
    );

    cv32e40s_sat_counter #(.WIDTH(CNT_W)) u_fault_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (fault_inc),
        .clr_i   (clear_i),
        .count_o (fault_cnt_o)
    );

    assign alert_o        = alert_q;
    assign halt_req_o     = halt_req_q;
    assign recover_req_o  = recover_req_q;
    assign fault_sticky_o = sticky_q;

endmodule

// File: doc/cv32e40s_lockstep_fault_handler.md
CV32E40S_LOCKSTEP_FAULT_HANDLER -- requirements
Module: cv32e40s_lockstep_fault_handler

Interface
REQ-001 SHALL have parameter CONFIRM_CYCLES, default 2: consecutive mismatch cycles needed to declare a fault; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the event counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  sole clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 enable_i  input  1  lockstep checking enabled; 0 masks error_i.
REQ-007 error_i  input  1  raw per-cycle mismatch from the master/checker comparator.
REQ-008 halt_ack_i  input  1  both cores halted.
REQ-009 recover_done_i  input  1  resynchronisation of both cores complete.
REQ-010 clear_i  input  1  software clear of sticky flag and counters.
REQ-011 alert_o  output  1  one-cycle pulse on fault declaration.
REQ-012 halt_req_o  output  1  level request to halt both cores.
REQ-013 recover_req_o  output  1  level request to resynchronise the cores.
REQ-014 fault_sticky_o  output  1  a fault has been declared since the last clear.
REQ-015 transient_cnt_o  output  CNT_W  count of mismatch bursts shorter than CONFIRM_CYCLES.
REQ-016 fault_cnt_o  output  CNT_W  count of declared faults.

Function
REQ-017 FSM SHALL have states IDLE, CONFIRM, HALT, RECOVER.
REQ-018 IDLE: enable_i & error_i SHALL load run counter = 1 and go to CONFIRM, or go directly to HALT when CONFIRM_CYCLES == 1.
REQ-019 CONFIRM, enable_i & error_i: SHALL increment the run counter and go to HALT when the incremented value equals CONFIRM_CYCLES; otherwise stay in CONFIRM.
REQ-020 CONFIRM, error_i low with enable_i high: SHALL return to IDLE and increment transient_cnt_o.
REQ-021 CONFIRM, enable_i low: SHALL return to IDLE with no counter update.
REQ-022 On every transition into HALT, alert_o SHALL be 1 for exactly that cycle; fault_cnt_o SHALL increment and fault_sticky_o SHALL set in the same cycle.
REQ-023 HALT: halt_req_o SHALL be 1 from the cycle after alert_o until halt_ack_i is sampled high; then the FSM SHALL go to RECOVER.
REQ-024 RECOVER: recover_req_o SHALL be 1 until recover_done_i is sampled high; then the FSM SHALL go to IDLE.
REQ-025 halt_ack_i outside HALT and recover_done_i outside RECOVER SHALL be ignored.
REQ-026 error_i and enable_i SHALL be ignored in HALT and RECOVER.
REQ-027 All outputs SHALL be registered; fault latency SHALL be CONFIRM_CYCLES cycles from the first sampled mismatch to alert_o.
REQ-028 Counters SHALL saturate at all-ones and never wrap.
REQ-029 clear_i SHALL zero both counters and fault_sticky_o without changing FSM state; clear_i SHALL win over a same-cycle increment or set.
REQ-030 halt_req_o and recover_req_o SHALL never be high in the same cycle.

Reset
REQ-031 Reset asserted SHALL force IDLE with the run counter at 0 and all outputs at 0, including mid-HALT or mid-RECOVER.
REQ-032 The first state update after reset deassertion SHALL occur on the next rising clk_i edge.

Structure
REQ-033 Package cv32e40s_lockstep_pkg SHALL hold the FSM state enum and the default CONFIRM_CYCLES and CNT_W constants.
REQ-034 Saturating counter sub-module cv32e40s_sat_counter (increment, clear, width parameter) SHALL be instantiated twice.

Verification
REQ-035 Bench SHALL cover these directed scenarios:
- enable_i=1, error_i high 1 cycle -> transient_cnt_o=1, no alert_o, FSM back in IDLE.
- error_i high 2 cycles -> alert_o pulse on 2nd edge, fault_cnt_o=1, halt_req_o next cycle; halt_ack_i -> recover_req_o; recover_done_i -> IDLE.
- CNT_W=2: 5 short bursts -> transient_cnt_o saturates at 3.
- enable_i=0, error_i=1 for 10 cycles -> no counter or output change.
- rst_ni low during RECOVER -> all outputs 0 asynchronously; IDLE after release.
- clear_i in the same cycle as fault declaration -> fault_cnt_o=0 and fault_sticky_o=0, alert_o still pulses, halt_req_o still asserted next cycle.
